// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults and debounce counter type for the button capture path
package btn_pkg;
  localparam int BTN_N = 16;
  localparam int BTN_STABLE = 3;
  localparam int BTN_W = 4;
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] btn_cnt_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one channel (ports: clk, rstn, tick, raw in; state, press, rel out) - 2-FF sync, tick-gated debounce, edge pulses
module debounce_bit
  import btn_pkg::*;
#(
  parameter int STABLE = BTN_STABLE
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel
);
  logic s1, s2, last;
  btn_cnt_t cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      last <= 1'b0;
      state <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      last <= state;
      press <= state & ~last;
      rel <= ~state & last;
      if (tick) begin
        if (s2 == state) cnt <= '0;
        else if (cnt == btn_cnt_t'(STABLE - 1)) begin
          state <= ~state;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/btn_capture4.sv
// btn_capture4: debounced button capture (ports: clk, rstn, btn in; state, press, rel, tick out; toggle out when BTN_TOGGLE_EN is defined); rel carries the release strobes since release is a reserved word
module btn_capture4
  import btn_pkg::*;
#(
  parameter int N = BTN_N,
  parameter int STABLE = BTN_STABLE,
  parameter int W = BTN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] btn,
  output logic [W-1:0] state,
  output logic [W-1:0] press,
  output logic [W-1:0] rel,
  output logic         tick
`ifdef BTN_TOGGLE_EN
  ,
  output logic [W-1:0] toggle
`endif
);
  logic [N-1:0] pre;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pre <= '0;
      tick <= 1'b0;
    end else begin
      pre <= pre + 1'b1;
      tick <= &pre;
    end
  for (genvar i = 0; i < W; i++) begin : g_ch
    debounce_bit #(.STABLE(STABLE)) u_db (
      .clk(clk), .rstn(rstn), .tick(tick), .raw(btn[i]),
      .state(state[i]), .press(press[i]), .rel(rel[i])
    );
  end
`ifdef BTN_TOGGLE_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) toggle <= '0;
    else toggle <= toggle ^ press;
`endif
endmodule

// File: doc/btn_capture4.md
Name: btn_capture4

Overview:
- Input-side counterpart of the LED register path: captures raw pushbuttons/switches into a clean registered word.
- Raw async buttons go through a 2-FF synchronizer, then a prescaled-tick debouncer, then edge detection.
- Outputs are a stable level word plus one-cycle press/release strobes, for use by the board-level top (LED, counter and UART logic).

Parameters:
- N, 16, prescaler width; the sample tick fires once every 2^N clk cycles.
- STABLE, 3, number of consecutive ticks an input must differ from `state` before `state` flips (range 1..15).
- W, 4, number of button channels.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- btn  in  W  raw button/switch inputs, asynchronous to clk, active-high.
- state  out  W  debounced level of each button.
- press  out  W  one-cycle pulse per bit on a debounced 0->1 change.
- release  out  W  one-cycle pulse per bit on a debounced 1->0 change.
- tick  out  1  sample strobe, one clk wide, exported for reuse.

Behaviour:
- Reset (rstn low, asynchronous): synchronizer FFs, prescaler, all per-bit counters, state, press, release and tick all go to 0. Deassertion takes effect on the next clk edge.
- Synchronizer: sync = btn delayed by 2 clk (two FFs per bit). No logic between the two stages.
- Prescaler: N-bit free-running up-counter starting at 0, wrapping at 2^N-1.
  - tick is registered high for the cycle after the counter equals all ones.
  - The first tick after reset occurs at clk cycle 2^N.
- Per-bit debounce, evaluated only on cycles where tick=1:
  - sync == state: cnt <= 0.
  - sync != state and cnt < STABLE-1: cnt <= cnt+1.
  - sync != state and cnt == STABLE-1: state <= ~state, cnt <= 0.
  - Net effect: a flip needs STABLE consecutive differing ticks. One agreeing tick restarts the count; glitches between ticks are ignored.
  - cnt width is 4 bits.
- Edges:
  - press[i] and release[i] are registered from the state transition.
  - Each asserts for exactly one clk, the cycle after state[i] changes.
  - press and release of the same bit are never high together.
- Latency: from btn edge to state change is 2 clk plus the wait to the next tick, plus (STABLE-1)*2^N clk.
- Channels are fully independent; several bits may flip on the same tick.
- Reset mid-debounce discards partial counts. A button held through reset is reported as a press after STABLE ticks.
- No input is ever sampled combinationally to an output.

Optional Feature:
- Macro: BTN_TOGGLE_EN.
- Defined:
  - Adds output port `toggle` (W bits, reset 0).
  - toggle[i] inverts on each cycle press[i] is high, giving a latched on/off per button that can drive the LED register directly.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package `btn_pkg`:
  - default constants BTN_N=16, BTN_STABLE=3, BTN_W=4;
  - CNT_W=4;
  - debounce counter typedef (logic [CNT_W-1:0]).
- Sub-module `debounce_bit`:
  - one channel: synchronizer, counter, state, press/release;
  - inputs clk, rstn, tick, raw;
  - instantiated W times by generate.
- The prescaler stays in the top so all channels share one tick.

Test Plan (N=2, so a tick every 4 clk; STABLE=3; W=4):
- Reset hold then release, btn=0:
  - state=0, press=0, release=0 throughout;
  - tick first high at clk 4, then every 4 clk.
- btn[0] 0->1 held steady:
  - state[0] rises at the 3rd tick after sync[0] goes high, i.e. within 2+4+8 clk of the btn edge;
  - press[0] is high exactly 1 cycle after that;
  - other bits stay 0.
- btn[1] bounce: high for 5 clk, low for 3, then high steady:
  - no flip during the bounce;
  - state[1] sets only after 3 consecutive high ticks;
  - exactly one press[1] pulse.
- Release: btn[0] 1->0 steady after state[0]=1:
  - release[0] is a single pulse after 3 ticks;
  - press[0] stays 0.
- btn=4'b1111 applied at once:
  - all state bits flip on the same tick;
  - press=4'b1111 for one cycle.
- rstn pulsed low while cnt[2]=2:
  - everything clears asynchronously;
  - with btn[2] still high, state[2] sets 3 full ticks after reset release.
- With BTN_TOGGLE_EN: two separate debounced presses on btn[3] -> toggle[3] goes 0->1->0, one change per press.
